// File: rtl/anneal_sequencer.sv
// anneal_sequencer: run controller for an annealing node array.
// Each iteration issues random_run, dist_run (then waits DIST_LAT cycles),
// metropolis_run, an optional replica_run, exchange_run (then waits EXCH_LAT
// cycles) and toggles exchange_bank. Repeats for iter_num iterations, then
// pulses done.
// Optional feature macro: REPLICA_EXCHANGE_EN enables the REPL state; without
// it replica_run is tied low and no replica counter exists.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   start          begin a run (sampled only in IDLE)
//   abort          terminate the current run, no done pulse
//   iter_num[15:0] iterations per run, latched on accepted start
//   random_run, dist_run, metropolis_run, replica_run, exchange_run
//                  one-cycle run pulses (mutually exclusive)
//   exchange_bank  ordering bank select
//   busy           high in every state except IDLE
//   done           one-cycle pulse at normal run completion
module anneal_sequencer #(
    parameter int unsigned DIST_LAT      = 8,
    parameter int unsigned EXCH_LAT      = 32,
    parameter int unsigned REPL_INTERVAL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] iter_num,
    output logic        random_run,
    output logic        dist_run,
    output logic        metropolis_run,
    output logic        replica_run,
    output logic        exchange_run,
    output logic        exchange_bank,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] DIST_LAST = WAIT_W'(DIST_LAT - 1);
    localparam logic [WAIT_W-1:0] EXCH_LAST = WAIT_W'(EXCH_LAT - 1);

    // Elaboration-time parameter range checks
    if (DIST_LAT < 1 || DIST_LAT > 255) begin : g_bad_dist_lat
        $error("DIST_LAT out of range 1..255");
    end
    if (EXCH_LAT < 1 || EXCH_LAT > 255) begin : g_bad_exch_lat
        $error("EXCH_LAT out of range 1..255");
    end
    if (REPL_INTERVAL < 1 || REPL_INTERVAL > 65535) begin : g_bad_repl_interval
        $error("REPL_INTERVAL out of range 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAND  = 3'd1,
        DIST  = 3'd2,
        METRO = 3'd3,
        REPL  = 3'd4,
        EXCH  = 3'd5,
        WAIT  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    iter_cnt_q, iter_cnt_d;
    logic [CNT_W-1:0]    iter_max_q, iter_max_d;
    logic random_d, dist_d, metro_d, exch_d, bank_d, busy_d, done_d;

`ifdef REPLICA_EXCHANGE_EN
    localparam logic [CNT_W-1:0] REPL_LAST = CNT_W'(REPL_INTERVAL - 1);
    logic [CNT_W-1:0] repl_cnt_q, repl_cnt_d;
    logic             replica_d;
`else
    assign replica_run = 1'b0;
`endif

    // Next state, counters and next values of the registered outputs
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        iter_cnt_d = iter_cnt_q;
        iter_max_d = iter_max_q;
        random_d   = 1'b0;
        dist_d     = 1'b0;
        metro_d    = 1'b0;
        exch_d     = 1'b0;
        bank_d     = exchange_bank;
        done_d     = 1'b0;
`ifdef REPLICA_EXCHANGE_EN
        repl_cnt_d = repl_cnt_q;
        replica_d  = 1'b0;
`endif
        if (abort) begin
            // Abort wins over start and freezes the bank
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (iter_num == '0) begin
                            done_d = 1'b1;
                        end else begin
                            iter_max_d = iter_num;
                            iter_cnt_d = '0;
`ifdef REPLICA_EXCHANGE_EN
                            repl_cnt_d = '0;
`endif
                            state_d    = RAND;
                            random_d   = 1'b1;
                        end
                    end
                end
                RAND: begin
                    state_d = DIST;
                    dist_d  = 1'b1;
                    wait_d  = DIST_LAST;
                end
                DIST: begin
                    if (wait_q == '0) begin
                        state_d = METRO;
                        metro_d = 1'b1;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                METRO: begin
`ifdef REPLICA_EXCHANGE_EN
                    if (repl_cnt_q == REPL_LAST) begin
                        state_d   = REPL;
                        replica_d = 1'b1;
                    end else begin
                        state_d = EXCH;
                        exch_d  = 1'b1;
                    end
`else
                    state_d = EXCH;
                    exch_d  = 1'b1;
`endif
                end
                REPL: begin
                    state_d = EXCH;
                    exch_d  = 1'b1;
                end
                EXCH: begin
                    state_d = WAIT;
                    wait_d  = EXCH_LAST;
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        bank_d     = ~exchange_bank;
                        iter_cnt_d = iter_cnt_q + CNT_W'(1);
`ifdef REPLICA_EXCHANGE_EN
                        repl_cnt_d = (repl_cnt_q == REPL_LAST) ? '0
                                   : repl_cnt_q + CNT_W'(1);
`endif
                        if (iter_cnt_d == iter_max_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = RAND;
                            random_d = 1'b1;
                        end
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State, counters and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            iter_cnt_q     <= '0;
            iter_max_q     <= '0;
            random_run     <= 1'b0;
            dist_run       <= 1'b0;
            metropolis_run <= 1'b0;
            exchange_run   <= 1'b0;
            exchange_bank  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            iter_cnt_q     <= iter_cnt_d;
            iter_max_q     <= iter_max_d;
            random_run     <= random_d;
            dist_run       <= dist_d;
            metropolis_run <= metro_d;
            exchange_run   <= exch_d;
            exchange_bank  <= bank_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

`ifdef REPLICA_EXCHANGE_EN
    // Replica interval counter and its pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repl_cnt_q  <= '0;
            replica_run <= 1'b0;
        end else begin
            repl_cnt_q  <= repl_cnt_d;
            replica_run <= replica_d;
        end
    end
`endif

endmodule

// File: tb/tb_anneal_sequencer.sv
// tb_anneal_sequencer: scoreboard bench for anneal_sequencer (default
// parameters). Each accepted start expands into a timeline of expected pulse
// events; a negedge monitor pops and compares whenever a pulse appears.
module tb_anneal_sequencer;

    localparam int DL = 8;
    localparam int EL = 32;
    localparam int RI = 4;
`ifdef REPLICA_EXCHANGE_EN
    localparam bit REPL_EN = 1'b1;
`else
    localparam bit REPL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] iter_num = '0;
    logic random_run, dist_run, metropolis_run, replica_run, exchange_run;
    logic exchange_bank, busy, done;

    anneal_sequencer #(.DIST_LAT(DL), .EXCH_LAT(EL), .REPL_INTERVAL(RI)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .iter_num(iter_num), .random_run(random_run), .dist_run(dist_run),
        .metropolis_run(metropolis_run), .replica_run(replica_run),
        .exchange_run(exchange_run), .exchange_bank(exchange_bank),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Pulse vector: {random, dist, metro, repl, exch, done}
    typedef struct {
        int         cyc;
        logic [5:0] p;
        logic       bank;
        logic       busy;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  run_ev[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic model_bank = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every observed pulse against the head of the queue
    always @(negedge clk) begin
        logic [5:0] p;
        ev_t e;
        if (reset) begin
            p = {random_run, dist_run, metropolis_run, replica_run, exchange_run, done};
            if (p != 6'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse cycle=%0d got pulses=%b required none", cyc, p);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.p != p || e.bank !== exchange_bank || e.busy !== busy) begin
                        failures++;
                        $display("FAIL pulse_event got cyc=%0d pulses=%b bank=%b busy=%b required cyc=%0d pulses=%b bank=%b busy=%b",
                                 cyc, p, exchange_bank, busy, e.cyc, e.p, e.bank, e.busy);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_event got nothing by cycle=%0d required cyc=%0d pulses=%b", cyc, e.cyc, e.p);
            end
        end
    end

    // Reference timeline for a run of n iterations accepted in cycle t0
    task automatic build_run(input int n, input int t0);
        ev_t  e;
        int   t;
        logic b;
        run_ev.delete();
        b = model_bank;
        if (n == 0) begin
            e = '{t0 + 1, 6'b000001, b, 1'b0};
            run_ev.push_back(e);
        end else begin
            t = t0 + 1;
            for (int i = 0; i < n; i++) begin
                e = '{t, 6'b100000, b, 1'b1};      run_ev.push_back(e);
                e = '{t + 1, 6'b010000, b, 1'b1};  run_ev.push_back(e);
                t = t + 1 + DL;
                e = '{t, 6'b001000, b, 1'b1};      run_ev.push_back(e);
                t = t + 1;
                if (REPL_EN && ((i + 1) % RI) == 0) begin
                    e = '{t, 6'b000100, b, 1'b1};  run_ev.push_back(e);
                    t = t + 1;
                end
                e = '{t, 6'b000010, b, 1'b1};      run_ev.push_back(e);
                t = t + 1 + EL;
                b = ~b;
            end
            e = '{t, 6'b000001, b, 1'b0};
            run_ev.push_back(e);
        end
        model_bank = b;
        foreach (run_ev[i]) exp_q.push_back(run_ev[i]);
    endtask

    // Issue a start now (caller sits #1 after a posedge); optional abort at
    // offset abort_off; optional noise: starts and iter_num changes mid-run
    task automatic run_seq(input int n, input int abort_off, input bit noise);
        int t0, tdone, ta, c, last_busy;
        t0 = cyc;
        start = 1'b1;
        abort = 1'b0;
        iter_num = 16'(n);
        build_run(n, t0);
        tdone = run_ev[run_ev.size() - 1].cyc;
        ta = (abort_off > 0) ? t0 + abort_off : -1;
        last_busy = (ta > 0) ? ta : tdone - 1;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            c = cyc;
            start = 1'b0;
            abort = 1'b0;
            if (ta > 0 && c == ta + 1) begin
                while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > ta)
                    void'(exp_q.pop_back());
                foreach (run_ev[i]) if (run_ev[i].cyc <= ta) model_bank = run_ev[i].bank;
                checks++;
                if ({busy, done, exchange_bank} !== {1'b0, 1'b0, model_bank}) begin
                    failures++;
                    $display("FAIL abort_idle got busy/done/bank=%b%b%b required 00%b",
                             busy, done, exchange_bank, model_bank);
                end
                return;
            end
            if (ta < 0 && c >= tdone) return;
            if (ta > 0 && c == ta) abort = 1'b1;
            if (noise && $urandom_range(0, 3) == 0 && c <= last_busy) start = 1'b1;
            if (noise) iter_num = 16'($urandom);
        end
        checks++;
        failures++;
        $display("FAIL run_timeout got no completion by cycle=%0d required done by cycle=%0d", cyc, tdone);
    endtask

    task automatic idle_check(input string name);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s got busy=%b required 0", name, busy);
        end
    endtask

    initial begin
        int t0, n, ab;
        // Power-on reset: outputs must clear without a clock edge
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({random_run, dist_run, metropolis_run, replica_run, exchange_run,
             exchange_bank, busy, done} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs got %b required 00000000",
                     {random_run, dist_run, metropolis_run, replica_run, exchange_run, exchange_bank, busy, done});
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle_check("idle_after_reset");

        run_seq(1, 0, 1'b0);
        run_seq(8, 0, 1'b1);
        run_seq(0, 0, 1'b0);
        // Abort in DIST of iteration 3, then restart on the very next cycle
        run_seq(5, 90, 1'b0);
        run_seq(1, 0, 1'b0);

        // Abort together with start in IDLE: nothing may happen
        start = 1'b1; abort = 1'b1; iter_num = 16'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        idle_check("abort_start_idle");

        // Reset pulsed low during WAIT of the first iteration
        t0 = cyc;
        start = 1'b1; iter_num = 16'd3;
        build_run(3, t0);
        repeat (20) begin @(posedge clk); #1; start = 1'b0; end
        #2 reset = 1'b0;
        exp_q.delete();
        model_bank = 1'b0;
        #1;
        checks++;
        if ({random_run, dist_run, metropolis_run, replica_run, exchange_run,
             exchange_bank, busy, done} !== 8'b0) begin
            failures++;
            $display("FAIL reset_midrun got %b required 00000000",
                     {random_run, dist_run, metropolis_run, replica_run, exchange_run, exchange_bank, busy, done});
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        idle_check("idle_after_midrun_reset");
        run_seq(2, 0, 1'b1);

        // Randomised runs with aborts, noise and idle gaps
        for (int r = 0; r < 8; r++) begin
            n = int'($urandom_range(0, 5));
            ab = 0;
            if (n > 0 && $urandom_range(0, 2) == 0) ab = int'($urandom_range(1, 43 * n));
            run_seq(n, ab, 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending events required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anneal_sequencer.md
ANNEAL_SEQUENCER -- requirements
Module: anneal_sequencer

Interface
REQ-001 The module SHALL have parameter DIST_LAT, default 8, meaning cycles waited after dist_run for delta distance (legal 1..255).
REQ-002 The module SHALL have parameter EXCH_LAT, default 32, meaning cycles waited after exchange_run for ordering update (legal 1..255).
REQ-003 The module SHALL have parameter REPL_INTERVAL, default 4, meaning iterations between replica exchange tests (legal 1..65535).
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  begin a run; sampled only in IDLE.
REQ-007 Port abort  input  1  terminate the current run.
REQ-008 Port iter_num  input  16  iterations per run, sampled on accepted start.
REQ-009 Port random_run  output  1  one-cycle pulse to every node's random generator.
REQ-010 Port dist_run  output  1  one-cycle pulse starting the delta-distance calculation.
REQ-011 Port metropolis_run  output  1  one-cycle pulse for the metropolis test.
REQ-012 Port replica_run  output  1  one-cycle pulse for the replica exchange test.
REQ-013 Port exchange_run  output  1  one-cycle pulse for ordering change and replica exchange.
REQ-014 Port exchange_bank  output  1  ordering bank select, driven to all nodes.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port done  output  1  one-cycle pulse at normal run completion.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States SHALL be IDLE, RAND, DIST, METRO, REPL, EXCH, WAIT.
REQ-019 IDLE with start=1 and iter_num!=0 SHALL latch iter_num, clear iter_cnt and repl_cnt, and go to RAND.
REQ-020 IDLE with start=1 and iter_num=0 SHALL pulse done the next cycle and remain in IDLE.
REQ-021 RAND SHALL assert random_run for one cycle, then go to DIST.
REQ-022 DIST SHALL assert dist_run in its first cycle only and stay DIST_LAT cycles, then go to METRO.
REQ-023 METRO SHALL assert metropolis_run for one cycle, then go to REPL if repl_cnt==REPL_INTERVAL-1, else go to EXCH.
REQ-024 REPL SHALL assert replica_run for one cycle, then go to EXCH.
REQ-025 EXCH SHALL assert exchange_run for one cycle, then go to WAIT.
REQ-026 WAIT SHALL last EXCH_LAT cycles.
REQ-027 In the WAIT last cycle, exchange_bank SHALL toggle, iter_cnt SHALL increment, and repl_cnt SHALL increment, wrapping to 0 after REPL_INTERVAL-1.
REQ-028 Iteration length SHALL be 3+DIST_LAT+EXCH_LAT cycles, plus 1 cycle when a replica test is included.
REQ-029 When the incremented iter_cnt equals the latched iter_num, the next state SHALL be IDLE with done=1 for one cycle; otherwise the next state SHALL be RAND.
REQ-030 start while busy SHALL be ignored; a change of iter_num mid-run SHALL have no effect.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse, all run pulses low, and exchange_bank unchanged.
REQ-032 abort has priority over start in the same cycle; with abort=1 in IDLE the module SHALL remain in IDLE.
REQ-033 At most one of random_run, dist_run, metropolis_run, replica_run, exchange_run SHALL be high in any cycle.
REQ-034 The wait counter SHALL be 8 bits; iter_cnt and repl_cnt SHALL be 16 bits; no counter SHALL wrap within a legal configuration.

Reset
REQ-035 While reset=0, the state SHALL be IDLE and all counters 0.
REQ-036 While reset=0, random_run, dist_run, metropolis_run, replica_run, exchange_run, exchange_bank, busy and done SHALL all be 0, immediately and without a clock.
REQ-037 Reset assertion mid-run SHALL discard the run; after release the module SHALL need a new start.

Configuration
REQ-038 With macro REPLICA_EXCHANGE_EN defined, the REPL state and replica_run SHALL operate per REQ-023 and REQ-024.
REQ-039 Without REPLICA_EXCHANGE_EN, METRO SHALL always go to EXCH, replica_run SHALL be constant 0, repl_cnt SHALL be removed, and iteration length SHALL always be 3+DIST_LAT+EXCH_LAT.

Verification (DIST_LAT=8, EXCH_LAT=32, REPL_INTERVAL=4, REPLICA_EXCHANGE_EN defined unless noted)
REQ-040 Scenario: start with iter_num=1 -> random_run at cycle 1, dist_run at cycle 2, metropolis_run at cycle 10, exchange_run at cycle 11, exchange_bank=1 and done=1 at cycle 44, busy low at cycle 44.
REQ-041 Scenario: iter_num=8 -> exactly 8 pulses on each of random_run, dist_run, metropolis_run and exchange_run, 2 replica_run pulses (iterations 4 and 8), total 346 cycles to done, final exchange_bank=0.
REQ-042 Scenario: start with iter_num=0 -> done one cycle later, busy never high, no run pulses.
REQ-043 Scenario: abort in DIST of iteration 3 -> IDLE next edge, no done, exchange_bank=0 (two toggles), a new start accepted the following cycle.
REQ-044 Scenario: reset pulsed low during WAIT -> all outputs 0 asynchronously, IDLE after release, and start pulses while busy ignored in a separate run.
REQ-045 Scenario: REPLICA_EXCHANGE_EN undefined, iter_num=8 -> replica_run never high, done after 344 cycles.
